// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_W_DEFAULT = 8;

endpackage

// File: rtl/addsub_ext.sv
// (WIDTH+1)-bit adder/subtractor; operands are sign- or zero-extended by one bit.
module addsub_ext #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] S,
  input  logic             sub,
  input  logic             ext_signed,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;

  assign a_ext = {ext_signed & A[WIDTH-1], A};
  assign s_ext = {ext_signed & S[WIDTH-1], S};
  assign sum   = sub ? (a_ext - s_ext) : (a_ext + s_ext);

endmodule

// File: rtl/seq_mult_addshift.sv
// Signed shift-add multiplier, one multiplier bit per clock, start/done handshake.
// Define SEQ_MULT_UNSIGNED_EN to add the Is_Unsigned port for per-operation unsigned mode.
module seq_mult_addshift
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic [WIDTH-1:0]   Mplier,
`ifdef SEQ_MULT_UNSIGNED_EN
  input  logic               Is_Unsigned,
`endif
  output logic [2*WIDTH-1:0] Product,
  output logic               X,
  output logic               Busy,
  output logic               Done
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_t state, state_nxt;

  logic             x_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;

  logic             load;
  logic             step;
  logic             last;
  logic             uns;
  logic             sub;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

`ifdef SEQ_MULT_UNSIGNED_EN
  logic uns_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  uns_q <= 1'b0;
    else if (load) uns_q <= Is_Unsigned;
  end

  assign uns = uns_q;
`else
  assign uns = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and datapath controls, all decoded from the registered state
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      IDLE: load = Start;
      RUN: begin
        step = 1'b1;
        Busy = 1'b1;
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  // The multiplier's sign bit carries weight -2^(W-1), so its partial product is subtracted.
  assign last   = (cnt_q == LAST);
  assign addend = b_q[0] ? s_q : '0;
  assign sub    = b_q[0] & last & ~uns;

  addsub_ext #(.WIDTH(WIDTH)) u_addsub (
    .A          (a_q),
    .S          (addend),
    .sub        (sub),
    .ext_signed (~uns),
    .sum        (sum)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      x_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= Mplier;
      s_q   <= Mcand;
      cnt_q <= '0;
    end else if (step) begin
      x_q   <= sum[WIDTH];
      a_q   <= sum[WIDTH:1];
      b_q   <= {sum[0], b_q[WIDTH-1:1]};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign Product = {a_q, b_q};
  assign X       = x_q;

endmodule

// File: tb/tb_seq_mult_addshift.sv
// Directed bench for seq_mult_addshift: W=8 directed cases plus W=4 exhaustive sweep.
module tb_seq_mult_addshift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st8, st4;
  logic [7:0]  mc8, mp8;
  logic [3:0]  mc4, mp4;
  logic [15:0] p8;
  logic [7:0]  p4;
  logic        x8, bz8, d8;
  logic        x4, bz4, d4;
`ifdef SEQ_MULT_UNSIGNED_EN
  logic        u8, u4;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  seq_mult_addshift #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .Start(st8), .Mcand(mc8), .Mplier(mp8),
`ifdef SEQ_MULT_UNSIGNED_EN
    .Is_Unsigned(u8),
`endif
    .Product(p8), .X(x8), .Busy(bz8), .Done(d8)
  );

  seq_mult_addshift #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .Start(st4), .Mcand(mc4), .Mplier(mp4),
`ifdef SEQ_MULT_UNSIGNED_EN
    .Is_Unsigned(u4),
`endif
    .Product(p4), .X(x4), .Busy(bz4), .Done(d4)
  );

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b, input logic u);
    logic signed [15:0] sa, sb;
    if (u) return {8'h00, a} * {8'h00, b};
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb);
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    return 8'(sa * sb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for Done on the W=8 unit, counting negedges
  task automatic wait8(inout int cyc);
    while (!d8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic u, input string tag);
    int cyc;
    @(negedge clk);
    mc8 = a; mp8 = b; st8 = 1'b1;
`ifdef SEQ_MULT_UNSIGNED_EN
    u8 = u;
`endif
    q8.push_back(mul8(a, b, u));
    @(negedge clk);
    st8 = 1'b0;
    cyc = 1;
    wait8(cyc);
    chk({tag, " latency"}, 64'(cyc), 64'd9);
    chk({tag, " product"}, 64'(p8), 64'(q8.pop_front()));
    @(negedge clk);
    chk({tag, " done width"}, 64'(d8), 64'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int cyc;
    @(negedge clk);
    mc4 = a; mp4 = b; st4 = 1'b1;
    q4.push_back(mul4(a, b));
    @(negedge clk);
    st4 = 1'b0;
    cyc = 1;
    while (!d4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("w4 %0d*%0d latency", a, b), 64'(cyc), 64'd5);
    chk($sformatf("w4 %0d*%0d product", a, b), 64'(p4), 64'(q4.pop_front()));
    @(negedge clk);
    chk($sformatf("w4 %0d*%0d done width", a, b), 64'(d4), 64'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    st8 = 1'b0; st4 = 1'b0;
    mc8 = '0; mp8 = '0; mc4 = '0; mp4 = '0;
`ifdef SEQ_MULT_UNSIGNED_EN
    u8 = 1'b0; u4 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset outputs", 64'({p8, x8, bz8, d8}), 64'd0);
    rst_n = 1'b1;

    run8(8'd7, 8'hFD, 1'b0, "7*-3");
    chk("7*-3 literal", 64'(p8), 64'h0000_FFEB);
    chk("7*-3 x", 64'(x8), 64'd1);
    chk("7*-3 idle busy", 64'(bz8), 64'd0);

    run8(8'h80, 8'h80, 1'b0, "-128*-128");
    chk("-128*-128 literal", 64'(p8), 64'h4000);
    run8(8'h00, 8'h5A, 1'b0, "0*5a");
    chk("0*5a literal", 64'(p8), 64'h0000);
    run8(8'h7F, 8'h81, 1'b0, "127*-127");
    run8(8'hFF, 8'h01, 1'b0, "-1*1");

    // Start pulsed mid-run with different operands must be ignored
    @(negedge clk);
    mc8 = 8'd12; mp8 = 8'd11; st8 = 1'b1;
    q8.push_back(mul8(8'd12, 8'd11, 1'b0));
    @(negedge clk);
    st8 = 1'b0;
    repeat (2) @(negedge clk);
    mc8 = 8'd99; mp8 = 8'd3; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    cyc = 4;
    wait8(cyc);
    chk("ignored start latency", 64'(cyc), 64'd9);
    chk("ignored start product", 64'(p8), 64'(q8.pop_front()));
    @(negedge clk);
    chk("ignored start no restart", 64'(bz8), 64'd0);

    // Start held high: restarts on the first IDLE edge with operands present then
    @(negedge clk);
    mc8 = 8'd5; mp8 = 8'd6; st8 = 1'b1;
    q8.push_back(mul8(8'd5, 8'd6, 1'b0));
    repeat (3) @(negedge clk);
    mc8 = 8'hF7; mp8 = 8'd2;
    q8.push_back(mul8(8'hF7, 8'd2, 1'b0));
    cyc = 3;
    wait8(cyc);
    chk("held start first latency", 64'(cyc), 64'd9);
    chk("held start first product", 64'(p8), 64'(q8.pop_front()));
    @(negedge clk);
    chk("held start idle gap", 64'(bz8), 64'd0);
    @(negedge clk);
    chk("held start restart busy", 64'(bz8), 64'd1);
    st8 = 1'b0;
    cyc = 1;
    wait8(cyc);
    chk("held start second latency", 64'(cyc), 64'd9);
    chk("held start second product", 64'(p8), 64'(q8.pop_front()));
    @(negedge clk);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    mc8 = 8'd7; mp8 = 8'hFD; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-run reset outputs", 64'({p8, x8, bz8, d8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'hFB, 8'd9, 1'b0, "post-reset -5*9");

`ifdef SEQ_MULT_UNSIGNED_EN
    run8(8'hFF, 8'hFF, 1'b1, "u 255*255");
    chk("u 255*255 literal", 64'(p8), 64'hFE01);
    run8(8'hFF, 8'hFF, 1'b0, "s -1*-1");
    chk("s -1*-1 literal", 64'(p8), 64'h0001);
`endif

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run4(4'(i), 4'(j));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
